// File: rtl/spin_pkg.sv
// Shared types and constants for the LED spinner motion sequencer:
// FSM state encoding, level-to-prescaler speed table and default sizing.
package spin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCEL   = 3'd1,
    ST_CRUISE  = 3'd2,
    ST_DECEL   = 3'd3,
    ST_REVERSE = 3'd4
  } state_e;

  localparam int DEFAULT_NUM_LEVELS = 6;
  localparam int DEFAULT_RAMP_TICKS = 4;

  // Entry [0] is the slowest running speed; entries 6 and 7 only exist so an
  // 8-level build still indexes a defined value (they repeat the fastest).
  localparam logic [7:0][3:0] LVL2SPEED = {
    4'h1, 4'h1, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hF
  };

  function automatic logic [3:0] lvl2speed(input logic [2:0] level);
    return LVL2SPEED[level];
  endfunction

endpackage

// File: rtl/spin_pos_counter.sv
// Modulo-NUM_LEDS up/down position counter for the LED ring; steps once per
// enabled cycle in the direction given by dir_i (1 = increment).
module spin_pos_counter #(
  parameter int NUM_LEDS = 8,
  parameter int POS_W    = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             dir_i,
  output logic [POS_W-1:0] pos_o
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_LEDS - 1);

  logic [POS_W-1:0] pos_q, pos_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (that would infer a latch).
    pos_d = pos_q;
    if (en_i) begin
      if (dir_i) pos_d = (pos_q == LAST_POS) ? '0 : pos_q + POS_W'(1);
      else       pos_d = (pos_q == '0) ? LAST_POS : pos_q - POS_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pos_q <= '0;
    else         pos_q <= pos_d;
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/spin_speed_ctrl.sv
// Motion sequencer for the LED spinner: ramps speed levels up/down on prescaler
// ticks, handles start/stop/reverse. Optional: `define AUTO_REVERSE_EN.
module spin_speed_ctrl
  import spin_pkg::*;
#(
  parameter int NUM_LEVELS   = DEFAULT_NUM_LEVELS,
  parameter int RAMP_TICKS   = DEFAULT_RAMP_TICKS,
  parameter int NUM_LEDS     = 8,
  parameter int POS_W        = 3,
  parameter int CRUISE_TICKS = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             rev_i,
  input  logic             tick_i,
  output logic [3:0]       speed_o,
  output logic [2:0]       level_o,
  output logic [POS_W-1:0] pos_o,
  output logic             dir_o,
  output logic             running_o,
  output logic [2:0]       state_o
);

  localparam logic [7:0] RAMP_LAST = 8'(RAMP_TICKS - 1);
  localparam logic [2:0] TOP_LEVEL = 3'(NUM_LEVELS - 1);

  state_e     state_q, state_d;
  logic [2:0] level_q, level_d;
  logic [7:0] cnt_q, cnt_d;
  logic       dir_q, dir_d;
  logic       rev_pend_q, rev_pend_d;
  logic [3:0] speed_q;
  logic       running_q;
  logic       ramp_done;

  // >= rather than == so a counter carried over from a longer phase still ramps.
  assign ramp_done = (cnt_q >= RAMP_LAST);

`ifdef AUTO_REVERSE_EN
  localparam logic [7:0] CRUISE_LAST = 8'(CRUISE_TICKS - 1);
`else
  logic unused_cruise_ticks;
  assign unused_cruise_ticks = |8'(CRUISE_TICKS);
`endif

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    rev_pend_d = rev_pend_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!stop_i) begin
          if (start_i) begin
            state_d = ST_ACCEL;
            level_d = '0;
            cnt_d   = '0;
          end else if (rev_i) begin
            dir_d = ~dir_q;
          end
        end
      end

      ST_ACCEL, ST_CRUISE: begin
        if (stop_i) begin
          state_d    = ST_DECEL;
          rev_pend_d = 1'b0;
          cnt_d      = '0;
        end else if (rev_i) begin
          // Reversal keeps the ramp counter so deceleration continues the cadence.
          state_d    = ST_DECEL;
          rev_pend_d = 1'b1;
        end else if (tick_i && state_q == ST_ACCEL) begin
          if (ramp_done) begin
            cnt_d   = '0;
            level_d = level_q + 3'd1;
            if (level_d == TOP_LEVEL) state_d = ST_CRUISE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
`ifdef AUTO_REVERSE_EN
        else if (tick_i) begin
          if (cnt_q >= CRUISE_LAST) begin
            state_d    = ST_DECEL;
            rev_pend_d = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
`endif
      end

      ST_DECEL: begin
        if (rev_i && !stop_i) rev_pend_d = 1'b1;
        if (tick_i) begin
          if (ramp_done) begin
            cnt_d = '0;
            if (level_q == '0) state_d = rev_pend_d ? ST_REVERSE : ST_IDLE;
            else               level_d = level_q - 3'd1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      ST_REVERSE: begin
        dir_d      = ~dir_q;
        rev_pend_d = 1'b0;
        level_d    = '0;
        cnt_d      = '0;
        state_d    = stop_i ? ST_DECEL : ST_ACCEL;
      end

      default: begin
        state_d = ST_IDLE;
        level_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      level_q    <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b1;
      rev_pend_q <= 1'b0;
      speed_q    <= lvl2speed(3'd0);
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      rev_pend_q <= rev_pend_d;
      speed_q    <= lvl2speed(level_d);
      running_q  <= (state_d != ST_IDLE);
    end
  end

  spin_pos_counter #(
    .NUM_LEDS (NUM_LEDS),
    .POS_W    (POS_W)
  ) u_pos (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (tick_i & running_q),
    .dir_i  (dir_q),
    .pos_o  (pos_o)
  );

  assign speed_o   = speed_q;
  assign level_o   = level_q;
  assign dir_o     = dir_q;
  assign running_o = running_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_spin_speed_ctrl.sv
// Self-checking bench for spin_speed_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural reference model.
module tb_spin_speed_ctrl;

  localparam int NL   = 6;
  localparam int RT   = 4;
  localparam int LEDS = 8;
  localparam int PW   = 3;

  localparam int S_IDLE    = 0;
  localparam int S_ACCEL   = 1;
  localparam int S_CRUISE  = 2;
  localparam int S_DECEL   = 3;
  localparam int S_REVERSE = 4;

  logic          clk_i   = 1'b0;
  logic          rst_ni  = 1'b0;
  logic          start_i = 1'b0;
  logic          stop_i  = 1'b0;
  logic          rev_i   = 1'b0;
  logic          tick_i  = 1'b0;
  logic [3:0]    speed_o;
  logic [2:0]    level_o;
  logic [PW-1:0] pos_o;
  logic          dir_o;
  logic          running_o;
  logic [2:0]    state_o;

  int checks = 0;
  int errors = 0;

  int spd_tbl [NL] = '{15, 5, 4, 3, 2, 1};

  int m_state, m_level, m_cnt, m_pos;
  bit m_dir, m_pend;

  spin_speed_ctrl #(
    .NUM_LEVELS   (NL),
    .RAMP_TICKS   (RT),
    .NUM_LEDS     (LEDS),
    .POS_W        (PW),
    .CRUISE_TICKS (32)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .rev_i     (rev_i),
    .tick_i    (tick_i),
    .speed_o   (speed_o),
    .level_o   (level_o),
    .pos_o     (pos_o),
    .dir_o     (dir_o),
    .running_o (running_o),
    .state_o   (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    m_state = S_IDLE; m_level = 0; m_cnt = 0; m_pos = 0; m_dir = 1; m_pend = 0;
  endtask

  // Reference behaviour: one call per clock edge with the inputs sampled there.
  task automatic model_step(input bit st, input bit sp, input bit rv, input bit tk);
    if (m_state != S_IDLE && tk)
      m_pos = m_dir ? (m_pos + 1) % LEDS : (m_pos + LEDS - 1) % LEDS;
    case (m_state)
      S_IDLE: if (!sp) begin
        if (st) begin m_state = S_ACCEL; m_level = 0; m_cnt = 0; end
        else if (rv) m_dir = !m_dir;
      end
      S_ACCEL, S_CRUISE: begin
        if (sp) begin m_state = S_DECEL; m_pend = 0; m_cnt = 0; end
        else if (rv) begin m_state = S_DECEL; m_pend = 1; end
        else if (tk && m_state == S_ACCEL) begin
          m_cnt++;
          if (m_cnt == RT) begin
            m_cnt = 0; m_level++;
            if (m_level == NL - 1) m_state = S_CRUISE;
          end
        end
      end
      S_DECEL: begin
        if (rv && !sp) m_pend = 1;
        if (tk) begin
          m_cnt++;
          if (m_cnt == RT) begin
            m_cnt = 0;
            if (m_level == 0) m_state = m_pend ? S_REVERSE : S_IDLE;
            else m_level--;
          end
        end
      end
      default: begin
        m_dir = !m_dir; m_pend = 0; m_level = 0; m_cnt = 0;
        m_state = sp ? S_DECEL : S_ACCEL;
      end
    endcase
  endtask

  function automatic logic [14:0] exp_vec();
    return {3'(m_state), 3'(m_level), 4'(spd_tbl[m_level]), 3'(m_pos), m_dir,
            m_state != S_IDLE};
  endfunction

  function automatic logic [14:0] act_vec();
    return {state_o, level_o, speed_o, pos_o, dir_o, running_o};
  endfunction

  // Drive one clock of inputs; returns #1 after the edge with pulses released.
  task automatic cyc(input bit st, input bit sp, input bit rv, input bit tk);
    start_i = st; stop_i = sp; rev_i = rv; tick_i = tk;
    @(posedge clk_i);
    model_step(st, sp, rv, tk);
    #1;
    start_i = 0; stop_i = 0; rev_i = 0; tick_i = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (9) cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);
    end
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    if (act_vec() !== 15'({3'd0, 3'd0, 4'hF, 3'd0, 1'b1, 1'b0})) begin
      errors++; $display("FAIL reset_hold got %h exp %h", act_vec(), exp_vec());
    end
    checks++;
    rst_ni = 1'b1;
    cyc(0, 0, 0, 1);
    if (act_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_release got %h exp %h", act_vec(), exp_vec());
    end
    checks++;
  endtask

  task automatic test_accel_cruise();
    cyc(1, 0, 0, 0);
    if (state_o !== 3'd1 || level_o !== 3'd0 || running_o !== 1'b1) begin
      errors++; $display("FAIL start state=%0d level=%0d run=%0b exp 1/0/1", state_o, level_o, running_o);
    end
    checks++;
    for (int t = 1; t <= 20; t++) begin
      ticks(1);
      if (t % 4 == 0) begin
        if (level_o !== 3'(t / 4)) begin
          errors++; $display("FAIL ramp_level tick %0d got %0d exp %0d", t, level_o, t / 4);
        end
        checks++;
      end
    end
    if (state_o !== 3'd2 || speed_o !== 4'h1 || pos_o !== 3'd4) begin
      errors++; $display("FAIL cruise state=%0d speed=%h pos=%0d exp 2/1/4", state_o, speed_o, pos_o);
    end
    checks++;
  endtask

  task automatic test_stop_decel();
    cyc(0, 1, 0, 0);
    if (state_o !== 3'd3 || level_o !== 3'd5) begin
      errors++; $display("FAIL stop_enter state=%0d level=%0d exp 3/5", state_o, level_o);
    end
    checks++;
    ticks(4);
    if (level_o !== 3'd4) begin
      errors++; $display("FAIL decel_step got %0d exp 4", level_o);
    end
    checks++;
    ticks(20);
    if (state_o !== 3'd0 || running_o !== 1'b0 || speed_o !== 4'hF || pos_o !== 3'd4) begin
      errors++; $display("FAIL stop_idle state=%0d run=%0b speed=%h pos=%0d exp 0/0/F/4",
                         state_o, running_o, speed_o, pos_o);
    end
    checks++;
    ticks(5);
    if (pos_o !== 3'd4) begin
      errors++; $display("FAIL idle_pos_frozen got %0d exp 4", pos_o);
    end
    checks++;
  endtask

  task automatic test_idle_rev();
    cyc(0, 0, 1, 0);
    if (dir_o !== 1'b0 || state_o !== 3'd0) begin
      errors++; $display("FAIL idle_rev dir=%0b state=%0d exp 0/0", dir_o, state_o);
    end
    checks++;
    cyc(0, 0, 1, 0);
    cyc(1, 1, 0, 0);
    if (state_o !== 3'd0 || dir_o !== 1'b1) begin
      errors++; $display("FAIL stop_beats_start state=%0d dir=%0b exp 0/1", state_o, dir_o);
    end
    checks++;
  endtask

  task automatic test_reverse();
    rst_ni = 1'b0; #2; rst_ni = 1'b1; model_reset();
    cyc(1, 0, 0, 0);
    ticks(12);
    if (level_o !== 3'd3 || pos_o !== 3'd4) begin
      errors++; $display("FAIL pre_rev level=%0d pos=%0d exp 3/4", level_o, pos_o);
    end
    checks++;
    cyc(0, 0, 1, 0);
    if (state_o !== 3'd3) begin
      errors++; $display("FAIL rev_decel got %0d exp 3", state_o);
    end
    checks++;
    ticks(16);
    if (state_o !== 3'd4 || dir_o !== 1'b1) begin
      errors++; $display("FAIL rev_state state=%0d dir=%0b exp 4/1", state_o, dir_o);
    end
    checks++;
    cyc(0, 0, 0, 0);
    if (state_o !== 3'd1 || dir_o !== 1'b0 || level_o !== 3'd0) begin
      errors++; $display("FAIL rev_accel state=%0d dir=%0b level=%0d exp 1/0/0", state_o, dir_o, level_o);
    end
    checks++;
    ticks(5);
    if (pos_o !== 3'd7 || level_o !== 3'd1) begin
      errors++; $display("FAIL ccw_wrap pos=%0d level=%0d exp 7/1", pos_o, level_o);
    end
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++; $display("FAIL rev_model got %h exp %h", act_vec(), exp_vec());
    end
    checks++;
  endtask

  task automatic test_stop_rev_same();
    for (int i = 0; i < 40 && m_state != S_CRUISE; i++) ticks(1);
    if (state_o !== 3'd2) begin
      errors++; $display("FAIL reach_cruise got %0d exp 2", state_o);
    end
    checks++;
    cyc(0, 1, 1, 0);
    if (state_o !== 3'd3) begin
      errors++; $display("FAIL stop_rev_decel got %0d exp 3", state_o);
    end
    checks++;
    ticks(24);
    if (state_o !== 3'd0 || dir_o !== 1'b0 || running_o !== 1'b0) begin
      errors++; $display("FAIL stop_rev_end state=%0d dir=%0b run=%0b exp 0/0/0",
                         state_o, dir_o, running_o);
    end
    checks++;
  endtask

  task automatic test_async_reset();
    cyc(1, 0, 0, 0);
    ticks(5);
    if (state_o !== 3'd1 || level_o !== 3'd1) begin
      errors++; $display("FAIL pre_areset state=%0d level=%0d exp 1/1", state_o, level_o);
    end
    checks++;
    #2 rst_ni = 1'b0;
    #2;
    if (act_vec() !== 15'({3'd0, 3'd0, 4'hF, 3'd0, 1'b1, 1'b0})) begin
      errors++; $display("FAIL async_reset got %h exp %h", act_vec(),
                         15'({3'd0, 3'd0, 4'hF, 3'd0, 1'b1, 1'b0}));
    end
    checks++;
    #1 rst_ni = 1'b1;
    model_reset();
    ticks(6);
    if (state_o !== 3'd0 || level_o !== 3'd0 || pos_o !== 3'd0) begin
      errors++; $display("FAIL post_areset state=%0d level=%0d pos=%0d exp 0/0/0",
                         state_o, level_o, pos_o);
    end
    checks++;
  endtask

  task automatic test_random();
    int ev;
    bit st, sp, rv, tk;
    for (int c = 0; c < 6000; c++) begin
      ev = int'($urandom_range(0, 59));
      st = 0; sp = 0; rv = 0; tk = 0;
      if (m_state == S_IDLE && ev < 4) st = 1;
      else if (ev == 10 && m_state != S_DECEL && m_state != S_IDLE) sp = 1;
      else if (ev == 11 && m_state != S_REVERSE) rv = 1;
      else if (ev == 12 && (m_state == S_ACCEL || m_state == S_CRUISE)) begin sp = 1; rv = 1; end
      else tk = ($urandom_range(0, 2) == 0);
      cyc(st, sp, rv, tk);
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d got %h exp %h", c, act_vec(), exp_vec());
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_accel_cruise();
    test_stop_decel();
    test_idle_rev();
    test_reverse();
    test_stop_rev_same();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
